// File: rtl/pkt_port_arbiter_pkg.sv
// Shared definitions for the packet port arbiter: FSM state encoding,
// the per-port header slot layout, field widths and a saturating counter
// helper used by the status counters.
package pkt_port_arbiter_pkg;

    localparam int DATA_W    = 32;
    localparam int KEEP_W    = 4;
    localparam int MAC_W     = 48;
    localparam int IP_W      = 32;
    localparam int UDP_W     = 16;
    localparam int PKT_CNT_W = 32;
    localparam int EVT_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        STREAM  = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic [MAC_W-1:0] dest_addr;
        logic [IP_W-1:0]  ip_dest_addr;
        logic [UDP_W-1:0] udp_dest_port;
        logic             encap;
    } hdr_slot_t;

    function automatic logic [EVT_CNT_W-1:0] sat_inc(input logic [EVT_CNT_W-1:0] v);
        return (v == '1) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pkt_port_arbiter_rr_select.sv
// Round-robin request selector (purely combinational).
//   req     : per-port request bits
//   ptr     : first index to consider; search wraps past NUM_PORTS-1 to 0
//   grant   : lowest requesting index at or after ptr
//   any_req : at least one request present (grant is 0 when none)
module rr_select
    import pkt_port_arbiter_pkg::*;
#(
    parameter  int NUM_PORTS = 4,
    localparam int PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PW-1:0]        ptr,
    output logic [PW-1:0]        grant,
    output logic                 any_req
);

    logic          found;
    logic [PW:0]   idx;

    always_comb begin
        grant   = '0;
        found   = 1'b0;
        idx     = '0;
        any_req = |req;
        for (int k = 0; k < NUM_PORTS; k++) begin
            // one spare bit so ptr+k cannot wrap before the modulo fold
            idx = {1'b0, ptr} + (PW+1)'(k);
            if (idx >= (PW+1)'(NUM_PORTS)) begin
                idx = idx - (PW+1)'(NUM_PORTS);
            end
            if (!found && req[idx[PW-1:0]]) begin
                grant = idx[PW-1:0];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pkt_port_arbiter.sv
// Arbitrates header+stream pairs from NUM_PORTS parser ports onto one
// header channel and one AXI-stream channel, round-robin, one packet at a time.
//   axis_clk / axis_reset     : clock, synchronous active-high reset
//   s_hdr_*                   : per-port header pulse and fields, s_hdr_ready release pulse
//   s_axis_*                  : per-port input streams
//   m_hdr_*                   : granted header (valid/ready), m_hdr_port = source port
//   m_axis_*                  : granted stream, m_axis_tuser = source port
//   pkt_count/timeout_count/overflow_count : per-port status counters
//
// state   | meaning
// IDLE    | waiting for a pending header slot; picks next port round-robin
// HDR     | presenting the granted slot on m_hdr_*
// STREAM  | passing the granted port's stream through, stall timer running
// RELEASE | one-cycle s_hdr_ready pulse, pending clear, advance rr pointer
module pkt_port_arbiter
    import pkt_port_arbiter_pkg::*;
#(
    parameter  int NUM_PORTS      = 4,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int PW             = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                           axis_clk,
    input  logic                           axis_reset,
    input  logic [NUM_PORTS-1:0]           s_hdr_valid,
    input  logic [MAC_W*NUM_PORTS-1:0]     s_hdr_dest_addr,
    input  logic [IP_W*NUM_PORTS-1:0]      s_hdr_ip_dest_addr,
    input  logic [UDP_W*NUM_PORTS-1:0]     s_hdr_udp_dest_port,
    input  logic [NUM_PORTS-1:0]           s_hdr_encap,
    output logic [NUM_PORTS-1:0]           s_hdr_ready,
    input  logic [DATA_W*NUM_PORTS-1:0]    s_axis_tdata,
    input  logic [KEEP_W*NUM_PORTS-1:0]    s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]           s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]           s_axis_tlast,
    output logic [NUM_PORTS-1:0]           s_axis_tready,
    output logic                           m_hdr_valid,
    input  logic                           m_hdr_ready,
    output logic [MAC_W-1:0]               m_hdr_dest_addr,
    output logic [IP_W-1:0]                m_hdr_ip_dest_addr,
    output logic [UDP_W-1:0]               m_hdr_udp_dest_port,
    output logic                           m_hdr_encap,
    output logic [PW-1:0]                  m_hdr_port,
    output logic [DATA_W-1:0]              m_axis_tdata,
    output logic [KEEP_W-1:0]              m_axis_tkeep,
    output logic                           m_axis_tvalid,
    output logic                           m_axis_tlast,
    output logic [PW-1:0]                  m_axis_tuser,
    input  logic                           m_axis_tready,
    output logic [PKT_CNT_W*NUM_PORTS-1:0] pkt_count,
    output logic [EVT_CNT_W*NUM_PORTS-1:0] timeout_count,
    output logic [EVT_CNT_W*NUM_PORTS-1:0] overflow_count
);

    localparam int            SW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT_CYCLES - 1);

    arb_state_t             state_q, state_d;
    logic [PW-1:0]          grant_q, grant_d;
    logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [NUM_PORTS-1:0]   pending_q, pending_d;
    hdr_slot_t              slot_q [NUM_PORTS];
    hdr_slot_t              slot_d [NUM_PORTS];
    logic [PKT_CNT_W-1:0]   pkt_cnt_q [NUM_PORTS];
    logic [PKT_CNT_W-1:0]   pkt_cnt_d [NUM_PORTS];
    logic [EVT_CNT_W-1:0]   to_cnt_q  [NUM_PORTS];
    logic [EVT_CNT_W-1:0]   to_cnt_d  [NUM_PORTS];
    logic [EVT_CNT_W-1:0]   ovf_cnt_q [NUM_PORTS];
    logic [EVT_CNT_W-1:0]   ovf_cnt_d [NUM_PORTS];
    logic [SW-1:0]          stall_q, stall_d;
    logic [PW-1:0]          sel_grant;
    logic                   sel_any;
    logic                   beat;

    rr_select #(.NUM_PORTS(NUM_PORTS)) u_rr_select (
        .req     (pending_q),
        .ptr     (rr_ptr_q),
        .grant   (sel_grant),
        .any_req (sel_any)
    );

    always_ff @(posedge axis_clk) begin
        if (axis_reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            pending_q <= '0;
            stall_q   <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                slot_q[i]    <= '0;
                pkt_cnt_q[i] <= '0;
                to_cnt_q[i]  <= '0;
                ovf_cnt_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            pending_q <= pending_d;
            stall_q   <= stall_d;
            slot_q    <= slot_d;
            pkt_cnt_q <= pkt_cnt_d;
            to_cnt_q  <= to_cnt_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        pending_d = pending_q;
        stall_d   = stall_q;
        slot_d    = slot_q;
        pkt_cnt_d = pkt_cnt_q;
        to_cnt_d  = to_cnt_q;
        ovf_cnt_d = ovf_cnt_q;
        beat      = 1'b0;

        case (state_q)
            IDLE: begin
                if (sel_any) begin
                    grant_d = sel_grant;
                    state_d = HDR;
                end
            end
            HDR: begin
                if (m_hdr_ready) begin
                    stall_d = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                beat = s_axis_tvalid[grant_q] && m_axis_tready;
                if (beat) begin
                    stall_d = '0;
                    if (s_axis_tlast[grant_q]) begin
                        pkt_cnt_d[grant_q] = pkt_cnt_q[grant_q] + 32'd1;
                        state_d            = RELEASE;
                    end
                end else if (stall_q == STALL_LAST) begin
                    to_cnt_d[grant_q] = sat_inc(to_cnt_q[grant_q]);
                    state_d           = RELEASE;
                end else begin
                    stall_d = stall_q + SW'(1);
                end
            end
            RELEASE: begin
                pending_d[grant_q] = 1'b0;
                rr_ptr_d = (grant_q == PW'(NUM_PORTS - 1)) ? '0 : grant_q + PW'(1);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Header capture runs after the release clear so a pulse on the
        // port being released re-arms it instead of counting as overflow.
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (s_hdr_valid[i]) begin
                if (pending_q[i] && !(state_q == RELEASE && grant_q == PW'(i))) begin
                    ovf_cnt_d[i] = sat_inc(ovf_cnt_q[i]);
                end else begin
                    pending_d[i]              = 1'b1;
                    slot_d[i].dest_addr       = s_hdr_dest_addr[i*MAC_W +: MAC_W];
                    slot_d[i].ip_dest_addr    = s_hdr_ip_dest_addr[i*IP_W +: IP_W];
                    slot_d[i].udp_dest_port   = s_hdr_udp_dest_port[i*UDP_W +: UDP_W];
                    slot_d[i].encap           = s_hdr_encap[i];
                end
            end
        end
    end

    always_comb begin
        m_hdr_valid         = 1'b0;
        m_hdr_dest_addr     = '0;
        m_hdr_ip_dest_addr  = '0;
        m_hdr_udp_dest_port = '0;
        m_hdr_encap         = 1'b0;
        m_hdr_port          = '0;
        m_axis_tdata        = '0;
        m_axis_tkeep        = '0;
        m_axis_tvalid       = 1'b0;
        m_axis_tlast        = 1'b0;
        m_axis_tuser        = '0;
        s_axis_tready       = '0;
        s_hdr_ready         = '0;
        case (state_q)
            HDR: begin
                m_hdr_valid         = 1'b1;
                m_hdr_dest_addr     = slot_q[grant_q].dest_addr;
                m_hdr_ip_dest_addr  = slot_q[grant_q].ip_dest_addr;
                m_hdr_udp_dest_port = slot_q[grant_q].udp_dest_port;
                m_hdr_encap         = slot_q[grant_q].encap;
                m_hdr_port          = grant_q;
            end
            STREAM: begin
                m_axis_tdata           = s_axis_tdata[grant_q*DATA_W +: DATA_W];
                m_axis_tkeep           = s_axis_tkeep[grant_q*KEEP_W +: KEEP_W];
                m_axis_tvalid          = s_axis_tvalid[grant_q];
                m_axis_tlast           = s_axis_tlast[grant_q];
                m_axis_tuser           = grant_q;
                s_axis_tready[grant_q] = m_axis_tready;
            end
            RELEASE: s_hdr_ready[grant_q] = 1'b1;
            default: ;
        endcase
    end

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_status
        assign pkt_count[gi*PKT_CNT_W +: PKT_CNT_W]      = pkt_cnt_q[gi];
        assign timeout_count[gi*EVT_CNT_W +: EVT_CNT_W]  = to_cnt_q[gi];
        assign overflow_count[gi*EVT_CNT_W +: EVT_CNT_W] = ovf_cnt_q[gi];
    end

endmodule

// File: tb/tb_pkt_port_arbiter.sv
module tb_pkt_port_arbiter;

    localparam int NP = 4;

    logic            axis_clk = 1'b0;
    logic            axis_reset;
    logic [NP-1:0]   s_hdr_valid;
    logic [48*NP-1:0] s_hdr_dest_addr;
    logic [32*NP-1:0] s_hdr_ip_dest_addr;
    logic [16*NP-1:0] s_hdr_udp_dest_port;
    logic [NP-1:0]   s_hdr_encap;
    logic [NP-1:0]   s_hdr_ready;
    logic [32*NP-1:0] s_axis_tdata;
    logic [4*NP-1:0] s_axis_tkeep;
    logic [NP-1:0]   s_axis_tvalid;
    logic [NP-1:0]   s_axis_tlast;
    logic [NP-1:0]   s_axis_tready;
    logic            m_hdr_valid;
    logic            m_hdr_ready;
    logic [47:0]     m_hdr_dest_addr;
    logic [31:0]     m_hdr_ip_dest_addr;
    logic [15:0]     m_hdr_udp_dest_port;
    logic            m_hdr_encap;
    logic [1:0]      m_hdr_port;
    logic [31:0]     m_axis_tdata;
    logic [3:0]      m_axis_tkeep;
    logic            m_axis_tvalid;
    logic            m_axis_tlast;
    logic [1:0]      m_axis_tuser;
    logic            m_axis_tready;
    logic [32*NP-1:0] pkt_count;
    logic [16*NP-1:0] timeout_count;
    logic [16*NP-1:0] overflow_count;

    int checks   = 0;
    int failures = 0;
    int nb;
    int g;

    always #5 axis_clk = ~axis_clk;

    pkt_port_arbiter #(.NUM_PORTS(NP), .TIMEOUT_CYCLES(16)) dut (
        .axis_clk            (axis_clk),
        .axis_reset          (axis_reset),
        .s_hdr_valid         (s_hdr_valid),
        .s_hdr_dest_addr     (s_hdr_dest_addr),
        .s_hdr_ip_dest_addr  (s_hdr_ip_dest_addr),
        .s_hdr_udp_dest_port (s_hdr_udp_dest_port),
        .s_hdr_encap         (s_hdr_encap),
        .s_hdr_ready         (s_hdr_ready),
        .s_axis_tdata        (s_axis_tdata),
        .s_axis_tkeep        (s_axis_tkeep),
        .s_axis_tvalid       (s_axis_tvalid),
        .s_axis_tlast        (s_axis_tlast),
        .s_axis_tready       (s_axis_tready),
        .m_hdr_valid         (m_hdr_valid),
        .m_hdr_ready         (m_hdr_ready),
        .m_hdr_dest_addr     (m_hdr_dest_addr),
        .m_hdr_ip_dest_addr  (m_hdr_ip_dest_addr),
        .m_hdr_udp_dest_port (m_hdr_udp_dest_port),
        .m_hdr_encap         (m_hdr_encap),
        .m_hdr_port          (m_hdr_port),
        .m_axis_tdata        (m_axis_tdata),
        .m_axis_tkeep        (m_axis_tkeep),
        .m_axis_tvalid       (m_axis_tvalid),
        .m_axis_tlast        (m_axis_tlast),
        .m_axis_tuser        (m_axis_tuser),
        .m_axis_tready       (m_axis_tready),
        .pkt_count           (pkt_count),
        .timeout_count       (timeout_count),
        .overflow_count      (overflow_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge axis_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic hdr_set(input int p, input logic [47:0] da);
        s_hdr_valid[p]                 = 1'b1;
        s_hdr_dest_addr[p*48 +: 48]    = da;
        s_hdr_ip_dest_addr[p*32 +: 32] = da[31:0] ^ 32'hFFFF_0000;
        s_hdr_udp_dest_port[p*16 +: 16] = da[15:0] + 16'd1;
        s_hdr_encap[p]                 = da[0];
    endtask

    task automatic beat_set(input int p, input logic v, input logic [31:0] d, input logic l);
        s_axis_tvalid[p]        = v;
        s_axis_tdata[p*32 +: 32] = d;
        s_axis_tkeep[p*4 +: 4]  = 4'hF;
        s_axis_tlast[p]         = l;
    endtask

    task automatic wait_hdr();
        for (int w = 0; w < 20; w++) begin
            if (m_hdr_valid) break;
            cyc();
        end
        chk("hdr_wait", {63'd0, m_hdr_valid}, 64'd1);
    endtask

    task automatic do_reset();
        axis_reset = 1'b1;
        cyc();
        axis_reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // reset with every input active: nothing may leak through
        axis_reset          = 1'b1;
        s_hdr_valid         = '1;
        s_hdr_dest_addr     = '1;
        s_hdr_ip_dest_addr  = '0;
        s_hdr_udp_dest_port = '0;
        s_hdr_encap         = '1;
        s_axis_tdata        = '1;
        s_axis_tkeep        = '1;
        s_axis_tvalid       = '1;
        s_axis_tlast        = '1;
        m_hdr_ready         = 1'b1;
        m_axis_tready       = 1'b1;
        cyc();
        cyc();
        chk("rst_hdr_v",  {63'd0, m_hdr_valid}, 64'd0);
        chk("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        chk("rst_tlast",  {63'd0, m_axis_tlast}, 64'd0);
        chk("rst_tready", {60'd0, s_axis_tready}, 64'd0);
        chk("rst_hready", {60'd0, s_hdr_ready}, 64'd0);
        chk("rst_daddr",  {16'd0, m_hdr_dest_addr}, 64'd0);
        chk("rst_cnts",   {63'd0, |{pkt_count, timeout_count, overflow_count}}, 64'd0);
        s_hdr_valid   = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        m_hdr_ready   = 1'b0;
        axis_reset    = 1'b0;
        cyc();
        cyc();
        chk("rst_no_pend", {63'd0, m_hdr_valid}, 64'd0);

        // single port 2, latency and 3-beat packet
        hdr_set(2, 48'h0A0B0C0D0E0F);
        settle();
        chk("lat_t0", {63'd0, m_hdr_valid}, 64'd0);
        cyc();
        s_hdr_valid = '0;
        settle();
        chk("lat_t1", {63'd0, m_hdr_valid}, 64'd0);
        cyc();
        chk("lat_t2",    {63'd0, m_hdr_valid}, 64'd1);
        chk("sp_port",   {62'd0, m_hdr_port}, 64'd2);
        chk("sp_daddr",  {16'd0, m_hdr_dest_addr}, 64'h0A0B0C0D0E0F);
        chk("sp_ip",     {32'd0, m_hdr_ip_dest_addr}, 64'hF3F20E0F);
        chk("sp_udp",    {48'd0, m_hdr_udp_dest_port}, 64'h0E10);
        chk("sp_encap",  {63'd0, m_hdr_encap}, 64'd1);
        chk("sp_no_tv",  {63'd0, m_axis_tvalid}, 64'd0);
        m_hdr_ready = 1'b1;
        cyc();
        m_hdr_ready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            beat_set(2, 1'b1, 32'hD000_0000 + b, b == 2);
            settle();
            chk("sp_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
            chk("sp_tdata",  {32'd0, m_axis_tdata}, 64'hD000_0000 + b);
            chk("sp_tkeep",  {60'd0, m_axis_tkeep}, 64'hF);
            chk("sp_tuser",  {62'd0, m_axis_tuser}, 64'd2);
            chk("sp_tlast",  {63'd0, m_axis_tlast}, (b == 2) ? 64'd1 : 64'd0);
            chk("sp_sready", {60'd0, s_axis_tready}, 64'b0100);
            cyc();
        end
        beat_set(2, 1'b0, 32'd0, 1'b0);
        settle();
        chk("sp_rel",     {60'd0, s_hdr_ready}, 64'b0100);
        chk("sp_pkt",     {32'd0, pkt_count[2*32 +: 32]}, 64'd1);
        chk("sp_rel_tv",  {63'd0, m_axis_tvalid}, 64'd0);
        chk("sp_rel_trd", {60'd0, s_axis_tready}, 64'd0);
        cyc();
        chk("sp_rel_1cy", {60'd0, s_hdr_ready}, 64'd0);

        // fairness: all four pulse together, each re-pulses after its release
        do_reset();
        for (int p = 0; p < NP; p++) hdr_set(p, 48'hA0 + p);
        cyc();
        s_hdr_valid = '0;
        for (int k = 0; k < 5; k++) begin
            g = k % 4;
            wait_hdr();
            chk("rr_port",  {62'd0, m_hdr_port}, 64'(g));
            chk("rr_daddr", {16'd0, m_hdr_dest_addr}, 64'hA0 + 64'(g));
            m_hdr_ready = 1'b1;
            cyc();
            m_hdr_ready = 1'b0;
            beat_set(g, 1'b1, 32'h100 + g, 1'b1);
            settle();
            chk("rr_tuser", {62'd0, m_axis_tuser}, 64'(g));
            cyc();
            beat_set(g, 1'b0, 32'd0, 1'b0);
            settle();
            chk("rr_rel", {60'd0, s_hdr_ready}, 64'd1 << g);
            cyc();
            hdr_set(g, 48'hA0 + g);
            cyc();
            s_hdr_valid = '0;
        end

        // backpressure on port 1, idle traffic on port 0, header on port 3 mid-stream
        do_reset();
        hdr_set(1, 48'h1111_2222_3333);
        cyc();
        s_hdr_valid = '0;
        wait_hdr();
        chk("bp_port", {62'd0, m_hdr_port}, 64'd1);
        m_hdr_ready = 1'b1;
        cyc();
        m_hdr_ready = 1'b0;
        beat_set(0, 1'b1, 32'hBAD0_BAD0, 1'b1);
        nb = 0;
        for (int c = 0; c < 12 && nb < 4; c++) begin
            m_axis_tready = (c % 2 == 0);
            beat_set(1, 1'b1, 32'hB000_0000 + nb, nb == 3);
            if (c == 1) hdr_set(3, 48'h3333_0000_0003);
            settle();
            chk("bp_sready", {60'd0, s_axis_tready}, (c % 2 == 0) ? 64'b0010 : 64'd0);
            chk("bp_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
            chk("bp_tdata",  {32'd0, m_axis_tdata}, 64'hB000_0000 + 64'(nb));
            if (c % 2 == 0) nb++;
            cyc();
            s_hdr_valid = '0;
        end
        chk("bp_beats", 64'(nb), 64'd4);
        beat_set(1, 1'b0, 32'd0, 1'b0);
        beat_set(0, 1'b0, 32'd0, 1'b0);
        m_axis_tready = 1'b1;
        settle();
        chk("bp_rel", {60'd0, s_hdr_ready}, 64'b0010);
        chk("bp_pkt", {32'd0, pkt_count[1*32 +: 32]}, 64'd1);
        cyc();
        wait_hdr();
        chk("bp_next_port",  {62'd0, m_hdr_port}, 64'd3);
        chk("bp_next_daddr", {16'd0, m_hdr_dest_addr}, 64'h3333_0000_0003);

        // timeout: port 3 never sends; port 0 becomes pending meanwhile
        m_hdr_ready = 1'b1;
        cyc();
        m_hdr_ready = 1'b0;
        hdr_set(0, 48'h0000_0000_00C0);
        cyc();
        s_hdr_valid = '0;
        repeat (14) cyc();
        chk("to_still_stream", {60'd0, s_axis_tready}, 64'b1000);
        chk("to_no_rel_yet",   {60'd0, s_hdr_ready}, 64'd0);
        cyc();
        chk("to_rel",   {60'd0, s_hdr_ready}, 64'b1000);
        chk("to_cnt",   {48'd0, timeout_count[3*16 +: 16]}, 64'd1);
        chk("to_pkt",   {32'd0, pkt_count[3*32 +: 32]}, 64'd0);
        chk("to_tlast", {63'd0, m_axis_tlast}, 64'd0);
        wait_hdr();
        chk("to_next_port",  {62'd0, m_hdr_port}, 64'd0);
        chk("to_next_daddr", {16'd0, m_hdr_dest_addr}, 64'hC0);

        // overflow, re-arm during release, reset mid-stream
        do_reset();
        hdr_set(1, 48'h0000_0000_0A01);
        cyc();
        hdr_set(1, 48'h0000_0000_0A02);
        cyc();
        s_hdr_valid = '0;
        chk("ov_cnt",   {48'd0, overflow_count[1*16 +: 16]}, 64'd1);
        chk("ov_hdr_v", {63'd0, m_hdr_valid}, 64'd1);
        chk("ov_keep",  {16'd0, m_hdr_dest_addr}, 64'hA01);
        m_hdr_ready = 1'b1;
        cyc();
        m_hdr_ready = 1'b0;
        beat_set(1, 1'b1, 32'h5, 1'b1);
        cyc();
        beat_set(1, 1'b0, 32'd0, 1'b0);
        hdr_set(1, 48'h0000_0000_0A03);
        settle();
        chk("sw_rel", {60'd0, s_hdr_ready}, 64'b0010);
        cyc();
        s_hdr_valid = '0;
        chk("sw_ovf", {48'd0, overflow_count[1*16 +: 16]}, 64'd1);
        cyc();
        chk("sw_hdr_v", {63'd0, m_hdr_valid}, 64'd1);
        chk("sw_daddr", {16'd0, m_hdr_dest_addr}, 64'hA03);
        m_hdr_ready = 1'b1;
        cyc();
        m_hdr_ready = 1'b0;
        beat_set(1, 1'b1, 32'h6, 1'b0);
        hdr_set(2, 48'h0000_0000_0A04);
        settle();
        chk("rs_tv_before", {63'd0, m_axis_tvalid}, 64'd1);
        axis_reset = 1'b1;
        cyc();
        s_hdr_valid = '0;
        settle();
        chk("rs_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        chk("rs_sready", {60'd0, s_axis_tready}, 64'd0);
        chk("rs_hready", {60'd0, s_hdr_ready}, 64'd0);
        chk("rs_hdr_v",  {63'd0, m_hdr_valid}, 64'd0);
        chk("rs_pkt",    {32'd0, pkt_count[1*32 +: 32]}, 64'd0);
        chk("rs_ovf",    {48'd0, overflow_count[1*16 +: 16]}, 64'd0);
        axis_reset = 1'b0;
        beat_set(1, 1'b0, 32'd0, 1'b0);
        repeat (3) begin
            cyc();
            chk("rs_no_hdr", {63'd0, m_hdr_valid}, 64'd0);
            chk("rs_no_rel", {60'd0, s_hdr_ready}, 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pkt_port_arbiter.md
PKT_PORT_ARBITER -- requirements
Module: pkt_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of parser ports arbitrated.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, stall cycles before a granted stream is force-released.
REQ-003 SHALL have ports axis_clk, in, 1, sole clock.
REQ-004 SHALL have ports axis_reset, in, 1, synchronous active-high reset.
REQ-005 SHALL have per-port header inputs:
- s_hdr_valid, in, NUM_PORTS, one-cycle header pulse.
- s_hdr_dest_addr, in, 48*NUM_PORTS.
- s_hdr_ip_dest_addr, in, 32*NUM_PORTS.
- s_hdr_udp_dest_port, in, 16*NUM_PORTS.
- s_hdr_encap, in, NUM_PORTS.
REQ-006 SHALL have s_hdr_ready, out, NUM_PORTS, one-cycle release pulse to the parser.
REQ-007 SHALL have per-port stream inputs:
- s_axis_tdata, in, 32*NUM_PORTS.
- s_axis_tkeep, in, 4*NUM_PORTS.
- s_axis_tvalid, in, NUM_PORTS.
- s_axis_tlast, in, NUM_PORTS.
REQ-008 SHALL have s_axis_tready, out, NUM_PORTS.
REQ-009 SHALL have header outputs m_hdr_valid (out, 1), m_hdr_ready (in, 1), m_hdr_dest_addr (out, 48), m_hdr_ip_dest_addr (out, 32), m_hdr_udp_dest_port (out, 16), m_hdr_encap (out, 1) and m_hdr_port (out, clog2(NUM_PORTS)).
REQ-010 SHALL have stream outputs m_axis_tdata (out, 32), m_axis_tkeep (out, 4), m_axis_tvalid (out, 1), m_axis_tlast (out, 1), m_axis_tuser (out, clog2(NUM_PORTS); source port) and m_axis_tready (in, 1).
REQ-011 SHALL have per-port status outputs pkt_count (out, 32*NUM_PORTS), timeout_count (out, 16*NUM_PORTS) and overflow_count (out, 16*NUM_PORTS).

Function
REQ-012 On s_hdr_valid[i]=1, SHALL latch the port-i header fields into a per-port slot and set pending[i] on the next edge.
REQ-013 If s_hdr_valid[i]=1 while pending[i]=1, SHALL keep the old slot, ignore the pulse and increment overflow_count[i], saturating at 16'hFFFF.
REQ-014 SHALL use FSM states IDLE, HDR, STREAM and RELEASE.
REQ-015 In IDLE with any pending bit set, SHALL pick the lowest index at or after rr_ptr, with wraparound; SHALL register grant; SHALL go to HDR.
REQ-016 In HDR, SHALL drive m_hdr_valid=1 with the granted slot and m_hdr_port=grant; SHALL go to STREAM on the cycle m_hdr_valid and m_hdr_ready are both 1.
REQ-017 In STREAM, SHALL route the granted port's tdata, tkeep, tvalid and tlast combinationally to m_axis_*, with m_axis_tuser=grant and s_axis_tready[grant]=m_axis_tready.
REQ-018 In STREAM, s_axis_tready of every non-granted port SHALL be 0.
REQ-019 In any state other than STREAM, m_axis_tvalid and all s_axis_tready bits SHALL be 0.
REQ-020 In STREAM, a beat with tlast=1, tvalid=1 and tready=1 SHALL increment pkt_count[grant] (wrapping) and move the FSM to RELEASE.
REQ-021 A stall counter SHALL reset on every accepted beat and on entry to STREAM.
REQ-022 When the stall counter reaches TIMEOUT_CYCLES-1, SHALL go to RELEASE, increment timeout_count[grant] (saturating) and emit no tlast.
REQ-023 RELEASE SHALL last exactly one cycle, in which it:
- pulses s_hdr_ready[grant].
- clears pending[grant].
- sets rr_ptr=grant+1 modulo NUM_PORTS.
- returns to IDLE.
REQ-024 If s_hdr_valid[grant] is 1 in the RELEASE cycle, the new header SHALL be captured and pending SHALL remain 1; set wins over clear.
REQ-025 Latency: a pulse at cycle T on an idle arbiter SHALL give pending at T+1 and m_hdr_valid=1 at T+2.
REQ-026 A header pulse on a non-granted port during STREAM SHALL only set pending and SHALL NOT disturb the active stream.

Reset
REQ-027 With axis_reset=1 at a clock edge, SHALL set state=IDLE, rr_ptr=0, grant=0, pending=0, all counters=0 and stall counter=0.
REQ-028 During and after reset, all valid, ready and last outputs, all s_hdr_ready bits and m_hdr_* data outputs SHALL be 0.
REQ-029 Reset asserted mid-STREAM SHALL abort the transfer without a release pulse and SHALL discard all pending slots.

Structure
REQ-030 A shared package SHALL hold the FSM state enum, the header-slot struct (dest_addr, ip_dest_addr, udp_dest_port, encap) and the field width constants.
REQ-031 The round-robin selector SHALL be a sub-module rr_select, with inputs req[NUM_PORTS] and ptr and outputs grant index and any_req, all combinational.

Verification
REQ-032 Single port: pulse on port 2 with dest_addr 48'h0A0B0C0D0E0F, then a 3-beat stream -> m_hdr_valid at T+2 with m_hdr_port=2, 3 beats with tuser=2, one-cycle s_hdr_ready[2], pkt_count[2]=1.
REQ-033 Fairness: ports 0..3 pulse in the same cycle, with each port re-pulsing in the cycle after its own release -> grant order 0,1,2,3,0 and no starvation.
REQ-034 Backpressure: m_axis_tready toggles 1,0,1,0 during a 4-beat packet -> all 4 beats delivered in order and non-granted tready=0 throughout.
REQ-035 Timeout with TIMEOUT_CYCLES=16: granted port holds tvalid=0 -> release after 16 stall cycles, timeout_count=1, next pending port granted.
REQ-036 Overflow and reset: a second pulse on a pending port gives overflow_count=1 with the first header retained; axis_reset mid-STREAM gives all outputs 0 at the next edge and pending=0.
